// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB segment constants, initiator state type and address check
package apb_pkg;

    localparam logic [31:0] APB_START_ADDRESS   = 32'h8c000000;
    localparam logic [31:0] APB_END_ADDRESS     = 32'h8c000100;
    localparam int          APB_MAX_WAIT_STATES = 0;

    // $clog2(1) is 0, so a zero wait budget still gets a one-bit counter
    localparam int WAIT_CNT_W = (APB_MAX_WAIT_STATES > 0) ? $clog2(APB_MAX_WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_initiator_state_t;

    // Word-aligned and inside the inclusive [lo, hi] window, unsigned compare
    function automatic logic apb_addr_legal(
        input logic [31:0] addr,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return (addr >= lo) && (addr <= hi) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/apb_initiator.sv
// rtl/apb_initiator.sv - single-beat command port to APB3 requester bridge
module apb_initiator
    import apb_pkg::*;
#(
    parameter logic [31:0] START_ADDRESS   = APB_START_ADDRESS,
    parameter logic [31:0] END_ADDRESS     = APB_END_ADDRESS,
    parameter int          MAX_WAIT_STATES = APB_MAX_WAIT_STATES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic        cmd_write_in,
    input  logic [31:0] cmd_addr_in,
    input  logic [31:0] cmd_wdata_in,
    output logic        rsp_valid_out,
    output logic [31:0] rsp_rdata_out,
    output logic        rsp_error_out,
    output logic        PSEL_OUT,
    output logic        PENABLE_OUT,
    output logic        PWRITE_OUT,
    output logic [31:0] PADDR_OUT,
    output logic [31:0] PWDATA_OUT,
    input  logic [31:0] PRDATA_IN,
    input  logic        PREADY_IN,
    input  logic        PSLVERR_IN
);

    // Counter width follows the instance parameter, which may exceed the package default
    localparam int              CNT_W   = (MAX_WAIT_STATES > 0) ? $clog2(MAX_WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT_STATES);

    apb_initiator_state_t state, state_nxt;

    logic             wr_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             cmd_legal;
    logic             wait_expired;

    assign cmd_legal    = apb_addr_legal(cmd_addr_in, START_ADDRESS, END_ADDRESS);
    assign wait_expired = (wait_cnt == MAX_CNT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_nxt     = state;
        cmd_ready_out = 1'b0;
        PSEL_OUT      = 1'b0;
        PENABLE_OUT   = 1'b0;
        rsp_valid_out = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_out = 1'b1;
                if (cmd_valid_in) begin
                    state_nxt = cmd_legal ? SETUP : RESP;
                end
            end
            SETUP: begin
                PSEL_OUT  = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL_OUT    = 1'b1;
                PENABLE_OUT = 1'b1;
                if (PREADY_IN || wait_expired) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid_out = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus and response fields are forced low outside the phases that own them
    assign PWRITE_OUT    = PSEL_OUT & wr_q;
    assign PADDR_OUT     = PSEL_OUT ? addr_q : 32'h0;
    assign PWDATA_OUT    = PWRITE_OUT ? wdata_q : 32'h0;
    assign rsp_rdata_out = rsp_valid_out ? rdata_q : 32'h0;
    assign rsp_error_out = rsp_valid_out & err_q;

    // Command latch, wait counting and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q     <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_in) begin
                        wr_q     <= cmd_write_in;
                        addr_q   <= cmd_addr_in;
                        wdata_q  <= cmd_write_in ? cmd_wdata_in : 32'h0;
                        wait_cnt <= '0;
                        rdata_q  <= 32'h0;
                        err_q    <= ~cmd_legal;
                    end
                end
                ACCESS: begin
                    if (PREADY_IN) begin
                        rdata_q <= wr_q ? 32'h0 : PRDATA_IN;
                        err_q   <= PSLVERR_IN;
                    end else if (wait_expired) begin
                        rdata_q <= 32'h0;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/apb_initiator.md
# apb_initiator

APB3 initiator (bus master) that converts single-beat commands from a local command port into APB transfers on the bus segment containing the audioport. Drives the requester side of the APB protocol: setup/access sequencing, wait-state limiting, address range checking and response return. Used by the system-level bench and integration top to issue register accesses to the audioport and other responders on the same segment.

## Interface
- START_ADDRESS, default apb_pkg::APB_START_ADDRESS (32'h8c000000): lowest legal bus address.
- END_ADDRESS, default apb_pkg::APB_END_ADDRESS (32'h8c000100): highest legal bus address, inclusive.
- MAX_WAIT_STATES, default apb_pkg::APB_MAX_WAIT_STATES (0): PREADY-low access cycles tolerated before abort.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid_in  in  1  command request.
- cmd_ready_out  out  1  command accepted when valid and ready are both high.
- cmd_write_in  in  1  1 = write, 0 = read.
- cmd_addr_in  in  32  byte address.
- cmd_wdata_in  in  32  write data.
- rsp_valid_out  out  1  one-cycle response pulse, no backpressure.
- rsp_rdata_out  out  32  read data, valid with rsp_valid_out.
- rsp_error_out  out  1  transfer failed, valid with rsp_valid_out.
- PSEL_OUT, PENABLE_OUT, PWRITE_OUT  out  1  APB controls.
- PADDR_OUT  out  32  APB address.
- PWDATA_OUT  out  32  APB write data.
- PRDATA_IN  in  32  APB read data.
- PREADY_IN  in  1  responder ready.
- PSLVERR_IN  in  1  responder error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready_out = 1; nothing else is driven high. On accept, register write, addr and wdata.
  - If addr < START_ADDRESS, addr > END_ADDRESS, or addr[1:0] != 0: go to RESP with error = 1. No bus activity.
  - Otherwise go to SETUP.
- SETUP: PSEL = 1, PENABLE = 0, PADDR/PWRITE/PWDATA hold the latched command. Next state is ACCESS.
- ACCESS: PSEL = 1, PENABLE = 1, bus signals stable. Wait counter starts at 0.
  - PREADY = 1: capture PRDATA (reads only; 0 for writes) and PSLVERR as error, then go to RESP.
  - PREADY = 0 and counter == MAX_WAIT_STATES: abort. Go to RESP with error = 1 and rdata = 0.
  - PREADY = 0 otherwise: increment counter and stay in ACCESS.
- RESP: rsp_valid_out = 1 for exactly one cycle, PSEL = 0, then back to IDLE.
- cmd_ready_out is low in SETUP, ACCESS and RESP. A command presented in those states waits.
- PWDATA_OUT is 0 on reads. PADDR/PWRITE/PWDATA hold their values from SETUP through the final ACCESS cycle.

## Timing
- Reset value of every output is 0, except cmd_ready_out = 1. State returns to IDLE and the wait counter clears.
- Reset asserted mid-transfer: PSEL/PENABLE are 0 after the next edge and no response is issued for the dropped command.
- Command accepted at edge 0. SETUP runs in cycle 1 and ACCESS in cycle 2.
- With PREADY high in cycle 2, rsp_valid_out is high in cycle 3 and cmd_ready_out goes high in cycle 4. Best-case throughput is one command per 4 cycles.
- Each wait state adds 1 cycle. An abort produces rsp_valid in cycle 3 + MAX_WAIT_STATES.
- Out-of-range or misaligned command: rsp_valid_out in cycle 1 with error = 1.
- PSLVERR_IN and PRDATA_IN are sampled only in the ACCESS cycle where PREADY is high.
- Boundary addresses START_ADDRESS and END_ADDRESS are legal. The address comparison is unsigned, 32 bits.

## Structure
- apb_pkg gains an apb_initiator_state_t enum (IDLE, SETUP, ACCESS, RESP).
- apb_pkg gains a WAIT_CNT_W localparam = $clog2(APB_MAX_WAIT_STATES+1), minimum 1.
- Address constants remain in apb_pkg and feed the parameter defaults.
- Single module, no sub-modules. The range check is a combinational function in apb_pkg (apb_addr_legal) so benches can reuse it.

## Test plan
- Write to 0x8c000004, data 0xDEADBEEF, PREADY tied 1: PSEL high cycles 1–2, PENABLE high cycle 2, PWDATA = 0xDEADBEEF; rsp_valid in cycle 3 with error = 0.
- Read from 0x8c000100 (END_ADDRESS), PRDATA = 0x12345678: rsp_rdata = 0x12345678 and error = 0. Read from 0x8c000104: no PSEL, rsp in cycle 1 with error = 1.
- MAX_WAIT_STATES = 2, PREADY low for 2 cycles then high: ACCESS lasts 3 cycles and the response arrives with error = 0. PREADY low for 3 cycles: abort, error = 1, rdata = 0, PSEL drops.
- PSLVERR = 1 with PREADY = 1 on a read: rsp_error = 1. Misaligned address 0x8c000002: error in cycle 1, no bus cycle.
- Assert rst during ACCESS: next cycle all APB outputs are 0, cmd_ready = 1, and no rsp_valid pulse appears. A following command completes normally.
- cmd_valid held high continuously for 3 commands: each is accepted only when cmd_ready is high. Accept edges are 4 cycles apart and responses come in order.
